register_file_writeback: RTL and testbench



---
 rtl/register_file_writeback.sv | 71 +++++++
 tb/tb_register_file_writeback.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/register_file_writeback.sv
// 32-entry architectural register file with a saturating committed-write counter; writes commit in 1 edge, reads are combinational, no backpressure.
// Define REGFILE_BYPASS_EN to forward the in-flight write-back word to matching read ports within the same cycle.
module register_file_writeback #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 5,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   Clock,
    input  logic                   ResetN,
    input  logic                   RegWrite,
    input  logic [ADDR_WIDTH-1:0]  WriteRegister,
    input  logic [DATA_WIDTH-1:0]  WriteBackResult,
    input  logic [ADDR_WIDTH-1:0]  ReadRegister1,
    input  logic [ADDR_WIDTH-1:0]  ReadRegister2,
    output logic [DATA_WIDTH-1:0]  ReadData1,
    output logic [DATA_WIDTH-1:0]  ReadData2,
    output logic [COUNT_WIDTH-1:0] WriteCount
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0]  regs [DEPTH];
    logic [COUNT_WIDTH-1:0] write_count;
    logic                   commit;

    // r0 is hardwired zero, so writes to it are neither stored nor counted.
    assign commit = RegWrite && (WriteRegister != '0);

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (commit) begin
            regs[WriteRegister] <= WriteBackResult;
        end
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            write_count <= '0;
        end else if (commit && (write_count != '1)) begin
            write_count <= write_count + COUNT_WIDTH'(1);
        end
    end

    assign WriteCount = write_count;

    always_comb begin
        ReadData1 = regs[ReadRegister1];
        ReadData2 = regs[ReadRegister2];
`ifdef REGFILE_BYPASS_EN
        // Bypass is suppressed under reset so every index reads zero while reset is held.
        if (ResetN && commit && (WriteRegister == ReadRegister1)) begin
            ReadData1 = WriteBackResult;
        end
        if (ResetN && commit && (WriteRegister == ReadRegister2)) begin
            ReadData2 = WriteBackResult;
        end
`else
        // Storage only: the pipeline forwards or stalls around same-cycle RAW.
`endif
        if (ReadRegister1 == '0) begin
            ReadData1 = '0;
        end
        if (ReadRegister2 == '0) begin
            ReadData2 = '0;
        end
    end

endmodule

// File: tb/tb_register_file_writeback.sv
// Directed bench for register_file_writeback: behavioural model plus per-cycle compare and literal spot checks.
// A second instance with a 4-bit counter shares all inputs to exercise saturation.
module tb_register_file_writeback;

    logic        Clock;
    logic        ResetN;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [31:0] WriteBackResult;
    logic [4:0]  ReadRegister1;
    logic [4:0]  ReadRegister2;
    logic [31:0] ReadData1, ReadData2;
    logic [15:0] WriteCount;
    logic [31:0] sat_rd1, sat_rd2;
    logic [3:0]  sat_count;

    int compared = 0;
    int mismatched = 0;
    bit started = 0;

    // Model state: plain array of register values and a raw count of committed writes.
    logic [31:0] model_mem [32];
    int          model_writes;

    register_file_writeback dut (
        .Clock(Clock), .ResetN(ResetN), .RegWrite(RegWrite),
        .WriteRegister(WriteRegister), .WriteBackResult(WriteBackResult),
        .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
        .ReadData1(ReadData1), .ReadData2(ReadData2), .WriteCount(WriteCount)
    );

    register_file_writeback #(.COUNT_WIDTH(4)) dut_sat (
        .Clock(Clock), .ResetN(ResetN), .RegWrite(RegWrite),
        .WriteRegister(WriteRegister), .WriteBackResult(WriteBackResult),
        .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
        .ReadData1(sat_rd1), .ReadData2(sat_rd2), .WriteCount(sat_count)
    );

    initial Clock = 0;
    always #5 Clock = ~Clock;

    always @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            for (int i = 0; i < 32; i++) model_mem[i] <= 32'h0;
            model_writes <= 0;
        end else if (RegWrite && WriteRegister != 5'd0) begin
            model_mem[WriteRegister] <= WriteBackResult;
            model_writes <= model_writes + 1;
        end
    end

    function automatic logic [31:0] exp_read(input logic [4:0] idx);
        if (!ResetN || idx == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (RegWrite && WriteRegister == idx) return WriteBackResult;
`endif
        return model_mem[idx];
    endfunction

    function automatic int sat_limit(input int n, input int lim);
        return (n > lim) ? lim : n;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, got, exp, $time);
        end
    endtask

    always @(negedge Clock) begin
        if (started) begin
            check("cyc_rd1", ReadData1, exp_read(ReadRegister1));
            check("cyc_rd2", ReadData2, exp_read(ReadRegister2));
            check("cyc_sat_rd1", sat_rd1, exp_read(ReadRegister1));
            check("cyc_count", {16'h0, WriteCount}, 32'(sat_limit(model_writes, 65535)));
            check("cyc_sat_count", {28'h0, sat_count}, 32'(sat_limit(model_writes, 15)));
        end
    end

    task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [4:0] r1, input logic [4:0] r2);
        @(posedge Clock);
        #1;
        RegWrite = we;
        WriteRegister = wa;
        WriteBackResult = wd;
        ReadRegister1 = r1;
        ReadRegister2 = r2;
    endtask

    task automatic pulse_reset;
        #2 ResetN = 0;
        #1 ResetN = 1;
    endtask

    initial begin
        ResetN = 0;
        RegWrite = 0;
        WriteRegister = 0;
        WriteBackResult = 0;
        ReadRegister1 = 5;
        ReadRegister2 = 31;
        #1 started = 1;
        @(posedge Clock);
        #2;
        check("reset_count", {16'h0, WriteCount}, 32'h0);
        check("reset_rd1", ReadData1, 32'h0);
        drive(1, 5'd5, 32'h1234_5678, 5'd5, 5'd0);
        #1 ResetN = 1;

        // Preload r5, then reset between edges must clear it immediately.
        drive(1, 5'd5, 32'h1234_5678, 5'd5, 5'd0);
        drive(0, 5'd0, 32'h0, 5'd5, 5'd5);
        #3 check("r5_preload", ReadData1, 32'h1234_5678);
        #2 ResetN = 0;
        #1;
        check("r5_in_reset", ReadData1, 32'h0);
        check("count_in_reset", {16'h0, WriteCount}, 32'h0);
        #1 ResetN = 1;

        // Reset held across an edge carrying a write: the write is lost.
        drive(1, 5'd6, 32'h5555_AAAA, 5'd6, 5'd6);
        #2 ResetN = 0;
        @(posedge Clock);
        #1 RegWrite = 0;
        #1 ResetN = 1;
        #1 check("r6_write_lost", ReadData1, 32'h0);

        drive(1, 5'd8, 32'hDEAD_BEEF, 5'd0, 5'd0);
        drive(0, 5'd0, 32'h0, 5'd8, 5'd8);
        #3;
        check("basic_rd1", ReadData1, 32'hDEAD_BEEF);
        check("basic_rd2", ReadData2, 32'hDEAD_BEEF);
        check("basic_count", {16'h0, WriteCount}, 32'h1);

        drive(1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
        #3 check("r0_bypass", ReadData1, 32'h0);
        drive(0, 5'd0, 32'h0, 5'd0, 5'd8);
        #3;
        check("r0_read", ReadData1, 32'h0);
        check("r0_count", {16'h0, WriteCount}, 32'h1);

        drive(1, 5'd9, 32'h1111_1111, 5'd0, 5'd0);
        drive(1, 5'd9, 32'h2222_2222, 5'd9, 5'd8);
`ifdef REGFILE_BYPASS_EN
        #3 check("raw_pre_edge", ReadData1, 32'h2222_2222);
`else
        #3 check("raw_pre_edge", ReadData1, 32'h1111_1111);
`endif
        check("raw_other_port", ReadData2, 32'hDEAD_BEEF);
        drive(0, 5'd0, 32'h0, 5'd9, 5'd9);
        #3;
        check("raw_post_edge", ReadData1, 32'h2222_2222);
        check("raw_count", {16'h0, WriteCount}, 32'h3);

        drive(0, 5'd3, 32'hABCD_0000, 5'd3, 5'd3);
        drive(0, 5'd0, 32'h0, 5'd3, 5'd9);
        #3;
        check("gate_r3", ReadData1, 32'h0);
        check("gate_count", {16'h0, WriteCount}, 32'h3);
        pulse_reset();

        for (int i = 1; i <= 17; i++) begin
            drive(1, 5'(i), 32'hA000_0000 + 32'(i), 5'(i - 1), 5'd1);
            if (i == 16) begin
                #3 check("sat_after_15", {28'h0, sat_count}, 32'd15);
            end
        end
        drive(0, 5'd0, 32'h0, 5'd17, 5'd15);
        #3;
        check("sat_after_17", {28'h0, sat_count}, 32'd15);
        check("wide_after_17", {16'h0, WriteCount}, 32'd17);
        check("r17_value", sat_rd1, 32'hA000_0011);
        check("r15_value", ReadData2, 32'hA000_000F);

        drive(0, 5'd0, 32'h0, 5'd0, 5'd0);
        @(posedge Clock);
        #2 started = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not complete, expected finish before 20000");
        $fatal(1, "timeout");
    end

endmodule
